// File: rtl/signed_div_sequencer.sv
// Sign-handling sequencer around the combinational non-restoring divider core.
// Feeds the core operand magnitudes, waits a fixed settle time, then sign-corrects into Z-lo/Z-hi.
module signed_div_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] core_dividend,
  output logic [31:0] core_divisor,
  input  logic [31:0] core_q,
  input  logic [31:0] core_r,
  output logic [31:0] z_lo,
  output logic [31:0] z_hi,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, WAIT, FIX, SPECIAL} state_t;

  state_t      state, state_nxt;
  logic        sd, sv;
  logic [7:0]  cnt;
  logic        bypass;
  logic [31:0] orig_dividend;

  // Zero and most-negative divisors fall outside the core's operating range.
  assign bypass = (divisor == '0) || (divisor == 32'h8000_0000);

  // The raw dividend is recovered from its registered magnitude and sign.
  assign orig_dividend = sd ? -core_dividend : core_dividend;

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = bypass ? SPECIAL : WAIT;
      WAIT:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      SPECIAL: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state         <= IDLE;
      sd            <= 1'b0;
      sv            <= 1'b0;
      cnt           <= '0;
      core_dividend <= '0;
      core_divisor  <= '0;
      z_lo          <= '0;
      z_hi          <= '0;
      done          <= 1'b0;
      div_by_zero   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sd            <= dividend[31];
            sv            <= divisor[31];
            core_dividend <= dividend[31] ? -dividend : dividend;
            core_divisor  <= divisor[31] ? -divisor : divisor;
            cnt           <= 8'(SETTLE_CYCLES - 1);
          end
        end
        WAIT: begin
          if (cnt != '0) cnt <= cnt - 8'd1;
        end
        FIX: begin
          z_lo        <= (sd ^ sv) ? -core_q : core_q;
          z_hi        <= sd ? -core_r : core_r;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
        end
        SPECIAL: begin
          done <= 1'b1;
          if (core_divisor == '0) begin
            z_lo        <= '1;
            z_hi        <= orig_dividend;
            div_by_zero <= 1'b1;
          end else begin
            div_by_zero <= 1'b0;
            // Divisor is -2^31 here; only a -2^31 dividend yields a nonzero quotient.
            if (core_dividend == 32'h8000_0000) begin
              z_lo <= 32'd1;
              z_hi <= '0;
            end else begin
              z_lo <= '0;
              z_hi <= orig_dividend;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_div_sequencer.sv
// Bench for signed_div_sequencer: a slow core model that returns garbage until operands settle,
// and a scoreboard of signed-division results checked on each done pulse.
module tb_signed_div_sequencer;

  localparam int unsigned S = 4;

  logic        clk = 1'b0;
  logic        clr, start;
  logic [31:0] dividend, divisor;
  logic [31:0] core_dividend, core_divisor, core_q, core_r;
  logic [31:0] z_lo, z_hi;
  logic        busy, done, div_by_zero;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  logic [64:0] exp_q[$];
  logic [31:0] last_lo = '0;

  logic [31:0] prev_a = '0, prev_b = '0;
  int unsigned age = 0;

  always #5 clk = ~clk;

  signed_div_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .clr(clr), .start(start), .dividend(dividend), .divisor(divisor),
    .core_dividend(core_dividend), .core_divisor(core_divisor),
    .core_q(core_q), .core_r(core_r), .z_lo(z_lo), .z_hi(z_hi),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  // Core answers are only trustworthy after the operands have been stable long enough.
  always @(posedge clk) begin
    if (core_dividend != prev_a || core_divisor != prev_b) begin
      prev_a <= core_dividend;
      prev_b <= core_divisor;
      age    <= 0;
    end else if (age < 1000) begin
      age <= age + 1;
    end
  end

  assign core_q = (age < S - 1) ? 32'hDEAD_BEEF :
                  (core_divisor == '0) ? '1 : core_dividend / core_divisor;
  assign core_r = (age < S - 1) ? 32'hBAD0_BAD0 :
                  (core_divisor == '0) ? core_dividend : core_dividend % core_divisor;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] mag(input logic [31:0] x);
    return x[31] ? -x : x;
  endfunction

  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] lo, hi;
    if (b == '0) return {1'b1, a, 32'hFFFF_FFFF};
    if (b == 32'h8000_0000)
      return (a == 32'h8000_0000) ? {1'b0, 32'd0, 32'd1} : {1'b0, a, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
    lo = $signed(a) / $signed(b);
    hi = $signed(a) % $signed(b);
    return {1'b0, hi, lo};
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit inject);
    int lat;
    logic [64:0] e;
    lat = (b == '0 || b == 32'h8000_0000) ? 1 : int'(S) + 1;
    exp_q.push_back(model(a, b));
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (inject && k == 1) begin
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
      end
      if (inject && k == 2) begin
        start = 1'b0; dividend = a; divisor = b;
      end
      check("busy", 32'(busy), 32'(k < lat));
      check("done", 32'(done), 32'(k == lat));
      if (k < lat) begin
        check("core_dividend", core_dividend, mag(a));
        check("core_divisor", core_divisor, mag(b));
        check("z_lo_hold", z_lo, last_lo);
      end
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (done) begin
        check("z_lo", z_lo, e[31:0]);
        check("z_hi", z_hi, e[63:32]);
        check("div_by_zero", 32'(div_by_zero), 32'(e[64]));
      end
      last_lo = e[31:0];
    end
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    check("rst_z_lo", z_lo, 32'd0);
    check("rst_z_hi", z_hi, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_core_dividend", core_dividend, 32'd0);
    check("rst_core_divisor", core_divisor, 32'd0);

    run_op(32'd7, 32'd2, 1'b0);
    run_op(-32'd7, 32'd2, 1'b0);
    run_op(32'd7, -32'd2, 1'b0);
    run_op(-32'd7, -32'd2, 1'b0);
    run_op(32'h1234, 32'd0, 1'b0);
    run_op(32'd9, 32'd3, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(32'd5, 32'h8000_0000, 1'b0);
    run_op(32'd1000, 32'd33, 1'b0);
    run_op(32'd7, 32'd2, 1'b1);
    @(posedge clk); #1;
    check("no_extra_done", 32'(done), 32'd0);

    run_op(-32'd5, 32'd0, 1'b0);
    @(posedge clk); #1;
    // Abort mid-wait: clr sampled at E2 clears everything and suppresses done.
    dividend = 32'd7; divisor = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_z_lo", z_lo, 32'd0);
    check("clr_z_hi", z_hi, 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_done", 32'(done), 32'd0);
    check("clr_dbz", 32'(div_by_zero), 32'd0);
    check("clr_core_dividend", core_dividend, 32'd0);
    check("clr_core_divisor", core_divisor, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("clr_no_done", 32'(done), 32'd0);
    end
    last_lo = '0;
    run_op(32'd20, 32'd6, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
